// File: rtl/vga_console_wb_master.sv
// Wishbone initiator that renders a byte stream onto a 40x30 VGA text controller.
// Bytes are queued, decoded as printable/CR/LF, and each glyph is programmed then polled.
module vga_console_wb_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        clear_i,
  input  logic [23:0] fg_color_i,
  input  logic [23:0] bg_color_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [4:0]  cursor_row_o,
  output logic [5:0]  cursor_col_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [3:0]  dbg_state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_POP, S_DECODE, S_WR_POS, S_WR_ASCII, S_WR_FG, S_WR_BG,
    S_WR_CTRL, S_RD_STAT, S_ADVANCE, S_CLR_BG, S_CLR_CTRL, S_CLR_STAT
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    byte_q;
  logic [4:0]    row_q;
  logic [5:0]    col_q;
  logic          err_q, clr_pend_q, clr_pend_d;
  logic          gap_q, stat_q;
  logic [TW-1:0] tmo_q;
  logic          cyc_q, we_q;
  logic [7:0]    adr_q;
  logic [31:0]   dat_q;

  logic full, empty, push, pop, printable, abort, clr_chain, clr_done;
  logic launch, l_we;
  state_t launch_st;
  logic [7:0]  l_adr;
  logic [31:0] l_dat;
  logic [4:0]  row_inc;
  logic unused_dat;

  assign unused_dat = ^wb_dat_i[31:1];
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign push       = in_valid_i && !full;
  assign pop        = (state_q == S_POP);
  assign printable  = (byte_q >= 8'h20) && (byte_q <= 8'h7E);
  assign row_inc    = (row_q == 5'd29) ? 5'd0 : row_q + 5'd1;
  // Ack outranks a simultaneous error or an expiring timeout.
  assign abort      = cyc_q && !wb_ack_i && (wb_err_i || tmo_q == TMO_LAST);
  assign clr_chain  = (state_q == S_CLR_BG) || (state_q == S_CLR_CTRL) || (state_q == S_CLR_STAT);
  assign clr_done   = (state_q == S_CLR_STAT) && !cyc_q && gap_q && !stat_q;
  assign clr_pend_d = clear_i || (clr_pend_q && !clr_done && !(abort && clr_chain));

  // A launch starts the next bus cycle; bus states launch only after their idle gap cycle.
  always_comb begin
    launch    = 1'b0;
    launch_st = S_IDLE;
    case (state_q)
      S_IDLE:     begin launch = clr_pend_q;       launch_st = S_CLR_BG;   end
      S_DECODE:   begin launch = printable;        launch_st = S_WR_POS;   end
      S_WR_POS:   begin launch = gap_q;            launch_st = S_WR_ASCII; end
      S_WR_ASCII: begin launch = gap_q;            launch_st = S_WR_FG;    end
      S_WR_FG:    begin launch = gap_q;            launch_st = S_WR_BG;    end
      S_WR_BG:    begin launch = gap_q;            launch_st = S_WR_CTRL;  end
      S_WR_CTRL:  begin launch = gap_q;            launch_st = S_RD_STAT;  end
      S_RD_STAT:  begin launch = gap_q && stat_q;  launch_st = S_RD_STAT;  end
      S_CLR_BG:   begin launch = gap_q;            launch_st = S_CLR_CTRL; end
      S_CLR_CTRL: begin launch = gap_q;            launch_st = S_CLR_STAT; end
      S_CLR_STAT: begin launch = gap_q && stat_q;  launch_st = S_CLR_STAT; end
      default:    ;
    endcase
  end

  always_comb begin
    l_adr = 8'h00;
    l_dat = 32'h0;
    l_we  = 1'b1;
    case (launch_st)
      S_WR_POS:               begin l_adr = 8'h08; l_dat = {19'd0, row_q, 2'b00, col_q}; end
      S_WR_ASCII:             begin l_adr = 8'h0C; l_dat = {24'd0, byte_q}; end
      S_WR_FG:                begin l_adr = 8'h10; l_dat = {8'd0, fg_color_i}; end
      S_WR_BG, S_CLR_BG:      begin l_adr = 8'h14; l_dat = {8'd0, bg_color_i}; end
      S_WR_CTRL:              begin l_adr = 8'h00; l_dat = 32'h1; end
      S_CLR_CTRL:             begin l_adr = 8'h00; l_dat = 32'h2; end
      S_RD_STAT, S_CLR_STAT:  begin l_adr = 8'h04; l_we = 1'b0; end
      default:                l_we = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;   wr_ptr_q <= '0;   rd_ptr_q <= '0;   byte_q <= 8'h00;
      row_q <= 5'd0;       col_q <= 6'd0;    err_q <= 1'b0;    clr_pend_q <= 1'b0;
      gap_q <= 1'b0;       stat_q <= 1'b0;   tmo_q <= '0;
      cyc_q <= 1'b0;       we_q <= 1'b0;     adr_q <= 8'h00;   dat_q <= 32'h0;
    end else begin
      clr_pend_q <= clr_pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (launch) begin
        state_q <= launch_st;
        cyc_q   <= 1'b1;  we_q <= l_we;  adr_q <= l_adr;  dat_q <= l_dat;
        tmo_q   <= '0;    gap_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (!empty) state_q <= S_POP;
          S_POP: begin
            byte_q  <= mem_q[rd_ptr_q[AW-1:0]];
            state_q <= S_DECODE;
          end
          S_DECODE: begin
            if (byte_q == 8'h0A) begin col_q <= 6'd0; row_q <= row_inc; end
            if (byte_q == 8'h0D) col_q <= 6'd0;
            state_q <= S_IDLE;
          end
          S_ADVANCE: begin
            if (col_q == 6'd39) begin col_q <= 6'd0; row_q <= row_inc; end
            else col_q <= col_q + 6'd1;
            state_q <= S_IDLE;
          end
          default: begin
            if (cyc_q) begin
              if (wb_ack_i || abort) begin
                cyc_q <= 1'b0;  we_q <= 1'b0;  adr_q <= 8'h00;  dat_q <= 32'h0;
              end
              if (wb_ack_i) begin
                gap_q  <= 1'b1;
                stat_q <= wb_dat_i[0];
              end else if (abort) begin
                err_q   <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                tmo_q <= tmo_q + 1'b1;
              end
            end else if (gap_q) begin
              gap_q <= 1'b0;
              if (state_q == S_RD_STAT) state_q <= S_ADVANCE;
              else begin
                row_q <= 5'd0;  col_q <= 6'd0;  err_q <= 1'b0;  state_q <= S_IDLE;
              end
            end
          end
        endcase
      end
    end
  end

  assign in_ready_o   = !full;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = 4'hF;
  assign cursor_row_o = row_q;
  assign cursor_col_o = col_q;
  assign busy_o       = (state_q != S_IDLE) || !empty || clr_pend_q;
  assign err_o        = err_q;
  assign dbg_state_o  = state_q;
endmodule

// File: doc/vga_console_wb_master.md
# vga_console_wb_master

Wishbone initiator that turns a byte stream into VGA text-controller register transactions. Bytes are buffered in an internal FIFO, interpreted as printable ASCII or cursor control, and each character is rendered by programming position, code and colors into the VGA character controller, issuing a render command and polling its busy flag. It sits between a CPU-side or UART-side byte source and the VGA controller's Wishbone slave port, and maintains the cursor on the 40x30 character grid.

## Interface
- FIFO_DEPTH, 16: input byte FIFO depth. Must be a power of 2, minimum 2.
- TIMEOUT, 255: maximum wait in cycles for wb_ack_i per bus cycle. Must be at least 1.
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset. Synchronous and active-high.
- in_data_i  in  8  input byte.
- in_valid_i  in  1  input byte valid.
- in_ready_o  out  1  high when the FIFO is not full. Reset value 1.
- clear_i  in  1  one-cycle pulse requesting a full-screen background fill and cursor home.
- fg_color_i  in  24  character color as RGB, 8:8:8.
- bg_color_i  in  24  background color as RGB, 8:8:8.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls. Reset value 0.
- wb_adr_o  out  8  byte address. Reset value 0.
- wb_dat_o  out  32  write data. Reset value 0.
- wb_sel_o  out  4  always 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1 each  slave response.
- cursor_row_o  out  5  current cursor row, 0–29. Reset value 0.
- cursor_col_o  out  6  current cursor column, 0–39. Reset value 0.
- busy_o  out  1  high when state≠IDLE, the FIFO is non-empty, or a clear is pending. Reset value 0.
- err_o  out  1  sticky error flag. Reset value 0. Cleared only by reset or by a completed clear.

## Operation
- Target register map:
  - 0x00 CONTROL: bit0 = render char, bit1 = fill background.
  - 0x04 STATUS: bit0 = busy.
  - 0x08 POS: row in [12:8], column in [5:0].
  - 0x0C ASCII.
  - 0x10 FG color.
  - 0x14 BG color.
- FIFO: push when in_valid_i && in_ready_o. in_ready_o = !full, and depends only on the full flag, so a push is refused when full even if a pop occurs in the same cycle.
- FSM states: IDLE, POP, DECODE, WR_POS, WR_ASCII, WR_FG, WR_BG, WR_CTRL, RD_STAT, ADVANCE, CLR_BG, CLR_CTRL, CLR_STAT.
- IDLE priority:
  - A pending clear goes to CLR_BG.
  - Otherwise a non-empty FIFO goes to POP.
  - Otherwise stay in IDLE.
- clear_i is latched into a clear-pending bit on any cycle and serviced at the next IDLE. It does not flush the FIFO.
- DECODE, by byte value:
  - 0x20–0x7E: goes to WR_POS.
  - 0x0A (LF): col=0, row+1.
  - 0x0D (CR): col=0.
  - All other bytes are dropped.
  - LF, CR and dropped bytes return to IDLE.
- Render chain, in order:
  - WR_POS writes {19'd0, row, 2'b0, col}.
  - WR_ASCII writes {24'd0, byte}.
  - WR_FG writes {8'd0, fg_color_i}.
  - WR_BG writes {8'd0, bg_color_i}.
  - WR_CTRL writes 32'h1.
  - RD_STAT reads; it repeats while wb_dat_i[0] is 1 and goes to ADVANCE when it reads 0.
- ADVANCE:
  - col+1.
  - col 39 wraps to col 0 with row+1.
  - row 29 +1 wraps to row 0. There is no scroll.
- Clear chain: CLR_BG writes bg_color_i, then CLR_CTRL writes 32'h2, then CLR_STAT polls as RD_STAT. It then sets cursor to (0,0), clears err_o and clears clear-pending.
- Colors are sampled at the cycle their write transaction starts.
- Error handling: wb_err_i, or no ack within TIMEOUT cycles, has the following effect:
  - The bus cycle ends.
  - err_o is set.
  - The current character or clear is abandoned without advancing the cursor, and the FSM returns to IDLE.
  - For a clear, clear-pending is also cleared.

## Timing
- Bus cycle:
  - cyc, stb, adr, dat and we are driven from the first cycle of the state and held stable until ack, err or timeout is sampled.
  - On that edge they drop to 0.
  - There is exactly one idle cycle (cyc=0) between consecutive transactions, including poll repeats.
- Ack in the same cycle as stb counts. Minimum 2 cycles per transaction.
- Timeout counter: reset at the start of each transaction. Abort fires on the edge where TIMEOUT cycles have elapsed without ack.
- POP: one cycle, byte registered. DECODE: one cycle. ADVANCE: one cycle.
- Minimum latency from push to the first wb_stb_o is 4 cycles: push, IDLE sees non-empty, POP, DECODE.
- Reset mid-transaction:
  - On the next edge cyc/stb go to 0, the FIFO is emptied, cursor is (0,0), and err_o and clear-pending are 0.
  - All outputs are at their reset values.

## Test plan
- Reset, push 'A' (0x41), with a slave model that acks in 1 cycle and reports busy for 3 status reads. Required bus writes:
  - 0x08 = 0x0.
  - 0x0C = 0x41.
  - 0x10 = fg.
  - 0x14 = bg.
  - 0x00 = 0x1.
  - Then 4 reads of 0x04.
  - Afterwards cursor is (0,1) and busy_o is 0.
- 40 printable bytes at (5,0): the cursor ends at (6,0). Then LF at col 7 gives (7,0), and CR gives col 0. Bytes 0x07 and 0x7F produce no bus traffic.
- With the cursor at (29,39), push 'Z': POS write = 0x1D27, and the cursor wraps to (0,0).
- Push 20 bytes into a stalled slave (ack withheld) with FIFO_DEPTH=16: in_ready_o drops at 16 entries, and further pushes are refused. After the slave recovers, all 16 queued bytes are rendered in order.
- Slave never acks, with TIMEOUT=8: stb drops after 8 cycles, err_o=1, the cursor is unchanged, and the next byte is processed. Then clear_i: writes 0x14 = bg and 0x00 = 0x2, polls, then cursor=(0,0) and err_o=0.
- Assert reset while stb is high during WR_ASCII: cyc/stb go to 0 next cycle, the FIFO is empty, and the cursor is (0,0).
